// File: rtl/list_sum_datapath.sv
// Linked-list summation datapath: list memory, node pointer and accumulator driven by controller load/select strobes.
// Optional saturation on accumulator overflow is enabled with macro LIST_SUM_SAT_EN (default: wrap, ovf tied low).
module list_sum_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] head_ptr,
    input  logic              sum_sel,
    input  logic              ld_sum,
    input  logic              pnt_sel,
    input  logic              ld_pnt,
    input  logic              a_sel,
    output logic              pnt_zero,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_pnt;
    logic [DATA_W-1:0] r_sum;

    logic [ADDR_W-1:0] w_pnt_inc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_next_word;
    logic [ADDR_W-1:0] w_next_ptr;
    logic [DATA_W:0]   w_sum_ext;

    // Memory is never reset; a write lands even in a reset cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_pnt_inc   = r_pnt + 1'b1;
    assign w_rd_addr   = a_sel ? r_pnt : w_pnt_inc;
    assign w_rd_data   = r_mem[w_rd_addr];
    assign w_next_word = r_mem[w_pnt_inc];
    assign w_next_ptr  = w_next_word[ADDR_W-1:0];
    assign pnt_zero    = (w_next_ptr == '0);
    assign w_sum_ext   = {1'b0, r_sum} + {1'b0, w_rd_data};

    generate
        if (DATA_W > ADDR_W) begin : g_ptr_hi
            logic w_unused_ptr_hi;
            assign w_unused_ptr_hi = ^w_next_word[DATA_W-1:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pnt <= '0;
        end else if (ld_pnt) begin
            r_pnt <= pnt_sel ? w_next_ptr : head_ptr;
        end
    end

`ifdef LIST_SUM_SAT_EN
    logic r_ovf;

    // Carry out clamps to all-ones; ovf holds until reset or an accumulator clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (ld_sum) begin
            if (!sum_sel) begin
                r_sum <= '0;
                r_ovf <= 1'b0;
            end else if (w_sum_ext[DATA_W]) begin
                r_sum <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_sum <= w_sum_ext[DATA_W-1:0];
            end
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (ld_sum) begin
            r_sum <= sum_sel ? w_sum_ext[DATA_W-1:0] : '0;
        end
    end

    assign w_unused_carry = w_sum_ext[DATA_W];
    assign ovf            = 1'b0;
`endif

    assign sum = r_sum;

endmodule

// File: tb/tb_list_sum_datapath.sv
// Directed self-checking bench for list_sum_datapath (DATA_W=8, ADDR_W=4).
module tb_list_sum_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] head_ptr;
    logic       sum_sel, ld_sum, pnt_sel, ld_pnt, a_sel;
    logic       pnt_zero;
    logic [7:0] sum;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    list_sum_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .head_ptr (head_ptr),
        .sum_sel  (sum_sel),
        .ld_sum   (ld_sum),
        .pnt_sel  (pnt_sel),
        .ld_pnt   (ld_pnt),
        .a_sel    (a_sel),
        .pnt_zero (pnt_zero),
        .sum      (sum),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of controls, then return the load strobes and write port to idle.
    task automatic step(input logic ls, input logic ss, input logic lp, input logic ps, input logic as);
        ld_sum  = ls;
        sum_sel = ss;
        ld_pnt  = lp;
        pnt_sel = ps;
        a_sel   = as;
        @(posedge clk);
        #1;
        ld_sum = 1'b0;
        ld_pnt = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic mem_wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic start(input logic [3:0] h);
        head_ptr = h;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic comp();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic get_next();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    logic [3:0] init_addr [15];
    logic [7:0] init_data [15];

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; head_ptr = '0;
        sum_sel = 1'b0; ld_sum = 1'b0; pnt_sel = 1'b0; ld_pnt = 1'b0; a_sel = 1'b1;

        init_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};
        init_data = '{8'd0, 8'd11, 8'd5, 8'd6, 8'd9, 8'h20, 8'd7, 8'd0,
                      8'd200, 8'd10, 8'd100, 8'd17, 8'd0, 8'd0, 8'd3};
        @(negedge clk);
        for (int i = 0; i < 15; i++) mem_wr(init_addr[i], init_data[i]);

        // Reset with both loads asserted and a concurrent memory write to 13.
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd13;
        wr_data = 8'd33;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        check_eq("rst_sum", sum, 8'd0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_pnt_zero", pnt_zero, 1'b0);

        // From pnt=0 follow mem[1]=11 to node 11 (value 17, next 0).
        get_next();
        check_eq("rst_pnt_next_zero", pnt_zero, 1'b1);
        comp();
        check_eq("rst_pnt_sum", sum, 8'd17);

        start(4'd13);
        check_eq("rstwr_start_sum", sum, 8'd0);
        comp();
        check_eq("rstwr_sum", sum, 8'd33);

        // Two-node list 2 -> 6.
        start(4'd2);
        check_eq("two_start_sum", sum, 8'd0);
        check_eq("two_pz_node2", pnt_zero, 1'b0);
        comp();
        check_eq("two_sum1", sum, 8'd5);
        get_next();
        check_eq("two_pz_node6", pnt_zero, 1'b1);
        comp();
        check_eq("two_sum2", sum, 8'd12);
        get_next();
        check_eq("two_final_sum", sum, 8'd12);
        check_eq("two_pz_null", pnt_zero, 1'b0);

        // Node at 15: next pointer read from wrapped address 0.
        start(4'd15);
        check_eq("wrap_pz", pnt_zero, 1'b1);
        comp();
        check_eq("wrap_sum", sum, 8'd3);

        // Node 4: next word 0x20 has zero low bits; then write/read collision.
        start(4'd4);
        check_eq("hi_bits_pz", pnt_zero, 1'b1);
        wr_en   = 1'b1;
        wr_addr = 4'd4;
        wr_data = 8'd20;
        comp();
        check_eq("coll_old_data", sum, 8'd9);
        comp();
        check_eq("coll_new_data", sum, 8'd29);

        // Overflow: 200 + 100 (+100).
        start(4'd8);
        comp();
        check_eq("ovf_sum1", sum, 8'd200);
        check_eq("ovf_flag1", ovf, 1'b0);
        get_next();
        check_eq("ovf_pz_node10", pnt_zero, 1'b0);
        comp();
`ifdef LIST_SUM_SAT_EN
        check_eq("ovf_sum2", sum, 8'd255);
        check_eq("ovf_flag2", ovf, 1'b1);
        comp();
        check_eq("ovf_sum3", sum, 8'd255);
        check_eq("ovf_flag3", ovf, 1'b1);
`else
        check_eq("ovf_sum2", sum, 8'd44);
        check_eq("ovf_flag2", ovf, 1'b0);
        comp();
        check_eq("ovf_sum3", sum, 8'd144);
        check_eq("ovf_flag3", ovf, 1'b0);
`endif
        start(4'd2);
        check_eq("ovf_clr_sum", sum, 8'd0);
        check_eq("ovf_clr_flag", ovf, 1'b0);

        // Simultaneous loads: add node 2's value and move to node 6 on one edge.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("sim_sum", sum, 8'd5);
        check_eq("sim_pz", pnt_zero, 1'b1);
        comp();
        check_eq("sim_sum_next", sum, 8'd12);

        // Accumulating with a_sel=0 adds the pointer word of node 2 (mem[3]=6).
        start(4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("asel0_sum", sum, 8'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
